// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: oversampled I2S/left-justified ADC receiver feeding a stereo-pair FWFT FIFO.
// Latency: a pair reaches the FIFO head 2 clock_50M cycles after the closing adclrc edge is detected.
// Backpressure: none toward the codec; a pair arriving while the FIFO is full (no pop) is dropped, overflow set.
// Ports: clock_50M/reset (sync, active-high); bclk/adclrc/adcdat async codec inputs;
//        rd_req pops the head pair, clr_err clears the sticky flags; rd_left/rd_right head pair;
//        fifo_empty/fifo_full/fifo_level occupancy; overflow/frame_err sticky error flags.
module i2s_adc_rx #(
  parameter int DATA_W     = 16,
  parameter int I2S_DELAY  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 2
) (
  input  logic              clock_50M,
  input  logic              reset,
  input  logic              bclk,
  input  logic              adclrc,
  input  logic              adcdat,
  input  logic              rd_req,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_left,
  output logic [DATA_W-1:0] rd_right,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [AW:0]       fifo_level,
  output logic              overflow,
  output logic              frame_err
);

  localparam int            CW      = $clog2(DATA_W + 1);
  localparam int            LW      = AW + 1;
  localparam logic [CW-1:0] C_WORD  = CW'(DATA_W);
  localparam logic [CW-1:0] C_SKIP  = CW'(I2S_DELAY);
  localparam logic [LW-1:0] C_DEPTH = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_SYNC, ST_SKIP, ST_SHIFT, ST_DONE} state_t;
  localparam state_t ST_START = (I2S_DELAY == 0) ? ST_SHIFT : ST_SKIP;

  // Synchronizers: [0] = s1, [1] = s2, [2] = s3 (edge-detect history).
  logic [2:0] r_bclk_s;
  logic [2:0] r_lrc_s;
  logic [1:0] r_dat_s;

  always_ff @(posedge clock_50M) begin
    if (reset) begin
      r_bclk_s <= '0;
      r_lrc_s  <= '0;
      r_dat_s  <= '0;
    end else begin
      r_bclk_s <= {r_bclk_s[1:0], bclk};
      r_lrc_s  <= {r_lrc_s[1:0], adclrc};
      r_dat_s  <= {r_dat_s[0], adcdat};
    end
  end

  logic w_bclk_rise, w_lrc_edge, w_lrc_lvl, w_bit;
  assign w_bclk_rise = r_bclk_s[1] & ~r_bclk_s[2];
  assign w_lrc_edge  = r_lrc_s[1] ^ r_lrc_s[2];
  assign w_lrc_lvl   = r_lrc_s[1];
  assign w_bit       = r_dat_s[1];

  // Deserializer FSM
  state_t              r_state, w_state, w_st1;
  logic [CW-1:0]       r_bitcnt, w_bitcnt, w_cnt1, w_cnt_inc;
  logic [DATA_W-1:0]   r_shift, w_shift, w_sh1;
  logic [DATA_W-1:0]   r_hold_left, w_hold_left;
  logic                r_chan, w_chan;
  logic                r_hold_vld, w_hold_vld;
  logic                w_wr_set, w_ferr_set;
  logic                r_wr_vld;
  logic [DATA_W-1:0]   r_wr_left, r_wr_right;

  always_ff @(posedge clock_50M) begin
    if (reset) begin
      r_state     <= ST_SYNC;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_hold_left <= '0;
      r_chan      <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_wr_vld    <= 1'b0;
      r_wr_left   <= '0;
      r_wr_right  <= '0;
    end else begin
      r_state     <= w_state;
      r_bitcnt    <= w_bitcnt;
      r_shift     <= w_shift;
      r_hold_left <= w_hold_left;
      r_chan      <= w_chan;
      r_hold_vld  <= w_hold_vld;
      r_wr_vld    <= w_wr_set;
      if (w_wr_set) begin
        r_wr_left  <= r_hold_left;
        r_wr_right <= r_shift;
      end
    end
  end

  // Two stages: the adclrc edge is resolved first (w_st1/w_cnt1/w_sh1), then a
  // coincident bclk rise is applied on top, so it counts toward the new channel.
  always_comb begin
    w_st1       = r_state;
    w_cnt1      = r_bitcnt;
    w_sh1       = r_shift;
    w_chan      = r_chan;
    w_hold_left = r_hold_left;
    w_hold_vld  = r_hold_vld;
    w_wr_set    = 1'b0;
    w_ferr_set  = 1'b0;

    if (r_state == ST_SYNC) begin
      // Only a falling adclrc edge (start of left) can open the first frame.
      if (w_lrc_edge && !w_lrc_lvl) begin
        w_st1      = ST_START;
        w_cnt1     = '0;
        w_sh1      = '0;
        w_chan     = 1'b0;
        w_hold_vld = 1'b0;
      end
    end else if (w_lrc_edge) begin
      if (r_state == ST_DONE) begin
        if (w_lrc_lvl) begin
          // Left word just finished.
          w_hold_left = r_shift;
          w_hold_vld  = !r_chan;
        end else begin
          // Right word just finished: emit only if a complete left preceded it.
          w_wr_set   = r_chan && r_hold_vld;
          w_hold_vld = 1'b0;
        end
      end else begin
        // Short channel: drop it and any pending left half.
        w_ferr_set = 1'b1;
        w_hold_vld = 1'b0;
      end
      w_st1  = ST_START;
      w_cnt1 = '0;
      w_sh1  = '0;
      w_chan = w_lrc_lvl;
    end

    w_state   = w_st1;
    w_bitcnt  = w_cnt1;
    w_shift   = w_sh1;
    w_cnt_inc = w_cnt1 + 1'b1;

    if (w_bclk_rise) begin
      case (w_st1)
        ST_SKIP: begin
          if (w_cnt_inc == C_SKIP) begin
            w_state  = ST_SHIFT;
            w_bitcnt = '0;
          end else begin
            w_bitcnt = w_cnt_inc;
          end
        end
        ST_SHIFT: begin
          w_shift  = {w_sh1[DATA_W-2:0], w_bit};
          w_bitcnt = w_cnt_inc;
          if (w_cnt_inc == C_WORD) w_state = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  // Stereo-pair FIFO, head always visible on rd_left/rd_right.
  logic [DATA_W-1:0] r_mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_r [FIFO_DEPTH];
  logic [AW:0]       r_wptr, r_rptr, w_level;
  logic              w_empty, w_full, w_pop, w_push, w_drop;

  assign w_level = r_wptr - r_rptr;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == C_DEPTH);
  assign w_pop   = rd_req & ~w_empty;
  // A same-cycle pop frees the slot the incoming pair needs.
  assign w_push  = r_wr_vld & (~w_full | w_pop);
  assign w_drop  = r_wr_vld & w_full & ~w_pop;

  always_ff @(posedge clock_50M) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_l[i] <= '0;
        r_mem_r[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_l[r_wptr[AW-1:0]] <= r_wr_left;
        r_mem_r[r_wptr[AW-1:0]] <= r_wr_right;
        r_wptr                  <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Sticky flags: a set in the same cycle as clr_err wins.
  always_ff @(posedge clock_50M) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w_drop)          overflow <= 1'b1;
      else if (clr_err)    overflow <= 1'b0;
      if (w_ferr_set)      frame_err <= 1'b1;
      else if (clr_err)    frame_err <= 1'b0;
    end
  end

  assign rd_left    = r_mem_l[r_rptr[AW-1:0]];
  assign rd_right   = r_mem_r[r_rptr[AW-1:0]];
  assign fifo_empty = w_empty;
  assign fifo_full  = w_full;
  assign fifo_level = w_level;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: directed bench for i2s_adc_rx (DATA_W=16, I2S_DELAY=1, FIFO_DEPTH=4).
// Codec side modelled with bclk = clock_50M/16; data and adclrc change on bclk falling edges.
// All inputs driven on clock_50M falling edges; outputs sampled on falling edges.
module tb_i2s_adc_rx;

  logic        clock_50M = 1'b0;
  logic        reset, bclk, adclrc, adcdat, rd_req, clr_err;
  logic [15:0] rd_left, rd_right;
  logic        fifo_empty, fifo_full, overflow, frame_err;
  logic [2:0]  fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] fl [5] = '{16'hC001, 16'h1357, 16'h8421, 16'h7FFE, 16'hDEAD};
  logic [15:0] fr [5] = '{16'h0001, 16'hFFFF, 16'h2468, 16'hBEEF, 16'h5A5A};
  logic [15:0] gl [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] gr [4] = '{16'hAAA1, 16'hAAA2, 16'hAAA3, 16'hAAA4};
  logic [15:0] w5;

  always #10 clock_50M = ~clock_50M;

  i2s_adc_rx #(.DATA_W(16), .I2S_DELAY(1), .FIFO_DEPTH(4), .AW(2)) dut (
    .clock_50M (clock_50M),
    .reset     (reset),
    .bclk      (bclk),
    .adclrc    (adclrc),
    .adcdat    (adcdat),
    .rd_req    (rd_req),
    .clr_err   (clr_err),
    .rd_left   (rd_left),
    .rd_right  (rd_right),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [15:0] l, input logic [15:0] r);
    check({tag, "_left"}, rd_left, l);
    check({tag, "_right"}, rd_right, r);
  endtask

  // One bclk half-period: 8 clock_50M cycles.
  task automatic half(input logic b, input logic l, input logic d);
    @(negedge clock_50M);
    bclk = b; adclrc = l; adcdat = d;
    repeat (7) @(negedge clock_50M);
  endtask

  // Slots first..last of a channel: slot 0 is the I2S delay slot, 1..16 carry
  // the word MSB first, the rest are pad bits (driven high so they must be ignored).
  task automatic send_slots(input logic lrc, input logic [15:0] word, input int first, input int last);
    logic b;
    for (int s = first; s <= last; s++) begin
      b = (s >= 1 && s <= 16) ? word[16 - s] : 1'b1;
      half(1'b0, lrc, b);
      half(1'b1, lrc, b);
    end
  endtask

  task automatic pop();
    @(negedge clock_50M); rd_req = 1'b1;
    @(negedge clock_50M); rd_req = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clock_50M); clr_err = 1'b1;
    @(negedge clock_50M); clr_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bclk = 1'b0; adclrc = 1'b1; adcdat = 1'b0; rd_req = 1'b0; clr_err = 1'b0;
    repeat (5) @(negedge clock_50M);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    check_head("rst_head", 16'h0000, 16'h0000);
    reset = 1'b0;

    // Idle in the right phase before the first frame.
    send_slots(1'b1, 16'h0000, 0, 3);

    // Basic I2S frame.
    send_slots(1'b0, 16'hA5C3, 0, 31);
    send_slots(1'b1, 16'h0F0F, 0, 31);
    check("t1_before_commit_empty", fifo_empty, 1);
    send_slots(1'b0, 16'h0000, 0, 0);
    check("t1_empty", fifo_empty, 0);
    check_head("t1_head", 16'hA5C3, 16'h0F0F);
    check("t1_level", fifo_level, 1);
    check("t1_overflow", overflow, 0);
    check("t1_frame_err", frame_err, 0);
    pop();
    check("t1_pop_empty", fifo_empty, 1);
    check("t1_pop_level", fifo_level, 0);

    // Five frames, no reads: fill then overflow.
    for (int i = 0; i < 5; i++) begin
      send_slots(1'b0, fl[i], 1, 31);
      send_slots(1'b1, fr[i], 0, 31);
      send_slots(1'b0, 16'h0000, 0, 0);
      if (i == 3) begin
        check("t2_full_after4", fifo_full, 1);
        check("t2_level_after4", fifo_level, 4);
        check("t2_no_overflow_yet", overflow, 0);
      end
    end
    check("t2_overflow", overflow, 1);
    check("t2_level_after5", fifo_level, 4);
    check("t2_frame_err", frame_err, 0);
    for (int i = 0; i < 4; i++) begin
      check_head("t2_drain", fl[i], fr[i]);
      pop();
    end
    check("t2_drained_empty", fifo_empty, 1);
    pulse_clr();
    check("t2_clr_overflow", overflow, 0);

    // Right channel truncated to 10 bclk.
    send_slots(1'b0, 16'h0AAA, 1, 31);
    send_slots(1'b1, 16'h0F00, 0, 9);
    check("t3_before_short_edge", frame_err, 0);
    send_slots(1'b0, 16'h0000, 0, 0);
    check("t3_frame_err", frame_err, 1);
    check("t3_no_write", fifo_empty, 1);
    send_slots(1'b0, 16'h1234, 1, 31);
    send_slots(1'b1, 16'h8001, 0, 31);
    send_slots(1'b0, 16'h0000, 0, 0);
    check_head("t3_recover", 16'h1234, 16'h8001);
    check("t3_level", fifo_level, 1);
    check("t3_frame_err_sticky", frame_err, 1);
    pop();
    pulse_clr();
    check("t3_clr_frame_err", frame_err, 0);
    check("t3_empty", fifo_empty, 1);

    // Reset in the middle of a left word, released while adclrc is high.
    send_slots(1'b0, 16'hFFFF, 1, 8);
    @(negedge clock_50M); reset = 1'b1;
    send_slots(1'b0, 16'hFFFF, 9, 31);
    send_slots(1'b1, 16'h5555, 0, 3);
    reset = 1'b0;
    check("t4_rst_empty", fifo_empty, 1);
    check("t4_rst_level", fifo_level, 0);
    send_slots(1'b1, 16'h5555, 4, 31);
    send_slots(1'b0, 16'h0000, 0, 0);
    check("t4_no_write_on_resync", fifo_empty, 1);
    send_slots(1'b0, 16'h00FF, 1, 31);
    send_slots(1'b1, 16'hFF00, 0, 31);
    send_slots(1'b0, 16'h0000, 0, 0);
    check_head("t4_pair", 16'h00FF, 16'hFF00);
    check("t4_level", fifo_level, 1);
    check("t4_frame_err", frame_err, 0);
    pop();

    // adclrc fall coincident with a bclk rise: that rise is the delay slot.
    send_slots(1'b0, 16'h0000, 1, 31);
    send_slots(1'b1, 16'h4321, 0, 31);
    w5 = 16'h8000;
    half(1'b0, 1'b1, 1'b1);
    half(1'b1, 1'b0, 1'b0);
    for (int k = 15; k >= 0; k--) begin
      half(1'b0, 1'b0, w5[k]);
      half(1'b1, 1'b0, w5[k]);
    end
    for (int k = 0; k < 15; k++) begin
      half(1'b0, 1'b0, 1'b1);
      half(1'b1, 1'b0, 1'b1);
    end
    send_slots(1'b1, 16'h7FFF, 0, 31);
    send_slots(1'b0, 16'h0000, 0, 0);
    check("t5_level", fifo_level, 2);
    check_head("t5_prev_pair", 16'h0000, 16'h4321);
    pop();
    check_head("t5_same_cycle", 16'h8000, 16'h7FFF);
    check("t5_frame_err", frame_err, 0);

    // FIFO full, write and pop in the same cycle.
    for (int i = 0; i < 3; i++) begin
      send_slots(1'b0, gl[i], 1, 31);
      send_slots(1'b1, gr[i], 0, 31);
      send_slots(1'b0, 16'h0000, 0, 0);
    end
    check("t6_full", fifo_full, 1);
    check("t6_level_full", fifo_level, 4);
    send_slots(1'b0, gl[3], 1, 31);
    send_slots(1'b1, gr[3], 0, 31);
    // Closing edge: pop lands in the write cycle (3rd clock after the edge reaches s2).
    @(negedge clock_50M); bclk = 1'b0; adclrc = 1'b0; adcdat = 1'b1;
    repeat (3) @(negedge clock_50M);
    rd_req = 1'b1;
    @(negedge clock_50M); rd_req = 1'b0;
    repeat (3) @(negedge clock_50M);
    half(1'b1, 1'b0, 1'b1);
    check("t6_level_kept", fifo_level, 4);
    check("t6_no_overflow", overflow, 0);
    check_head("t6_head", gl[0], gr[0]);
    for (int i = 1; i < 4; i++) begin
      pop();
      check_head("t6_order", gl[i], gr[i]);
    end
    pop();
    check("t6_final_empty", fifo_empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
